// File: rtl/demux8_rr_scheduler_pkg.sv
// Shared constants, state type and one-hot/index helpers for the 8-channel
// round-robin demux scheduler.
package demux_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    function automatic logic [NUM_CH-1:0] toOnehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] result;
        result      = '0;
        result[idx] = 1'b1;
        return result;
    endfunction

    // Highest set bit wins if more than one is set; grants are one-hot anyway.
    function automatic logic [SEL_W-1:0] toIndex(input logic [NUM_CH-1:0] oh);
        logic [SEL_W-1:0] result;
        result = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) begin
                result = SEL_W'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/demux8_rr_scheduler_if.sv
// Bundle of the scheduler's data/request/grant signals; the scheduler is the
// slave side, the channel environment is the master side.
interface demux8_rr_scheduler_if;
    import demux_sched_pkg::*;

    logic              in;
    logic [NUM_CH-1:0] req;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] grant;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] out;

    modport master (
        output in, req,
        input  sel, grant, busy, done, out
    );

    modport slave (
        input  in, req,
        output sel, grant, busy, done, out
    );

endinterface

// File: rtl/demux8_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel
// scanning upward from last+1, wrapping so that `last` itself is considered last.
module rr_arbiter8
    import demux_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any_req
);

    logic [SEL_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt_idx = last;
        w_idx   = last;
        any_req = |req;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = last + SEL_W'(i + 1);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/demux8_rr_scheduler_demux.sv
// Plain 1-to-8 demultiplexer: routes d to y[sel], all other outputs 0.
module demux1to8
    import demux_sched_pkg::*;
(
    input  logic              d,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] y
);

    always_comb begin
        y      = '0;
        y[sel] = d;
    end

endmodule

// File: rtl/demux8_rr_scheduler.sv
// Round-robin burst scheduler that owns the select of a 1-to-8 demux and
// routes the shared source bit to one granted channel at a time.
module demux8_rr_scheduler #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    demux8_rr_scheduler_if.slave bus
);
    import demux_sched_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t            r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_last;
    logic [NUM_CH-1:0] r_grant;
    logic              r_busy;
    logic [CNT_W-1:0]  r_count;

    logic [SEL_W-1:0]  w_arbLast;
    logic [SEL_W-1:0]  w_gntIdx;
    logic              w_anyReq;
    logic              w_reqHeld;
    logic              w_lastCycle;
    logic              w_burstEnd;
    logic              w_fullBurst;

    // While bursting, the channel being served gets lowest priority next.
    assign w_arbLast   = (r_state == BURST) ? r_sel : r_last;
    assign w_reqHeld   = bus.req[r_sel];
    assign w_lastCycle = (r_count == LAST_CNT);
    assign w_burstEnd  = (r_state == BURST) && (w_lastCycle || !w_reqHeld);
    assign w_fullBurst = (r_state == BURST) && w_lastCycle && w_reqHeld;

    rr_arbiter8 u_arbiter (
        .req     (bus.req),
        .last    (w_arbLast),
        .gnt_idx (w_gntIdx),
        .any_req (w_anyReq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= SEL_W'(NUM_CH - 1);
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_state <= BURST;
                        r_sel   <= w_gntIdx;
                        r_grant <= toOnehot(w_gntIdx);
                        r_busy  <= 1'b1;
                        r_count <= '0;
                    end
                end
                BURST: begin
                    if (w_burstEnd) begin
                        r_last <= r_sel;
                        // Re-arbitrate on the same edge so back-to-back bursts have no gap.
                        if (w_anyReq) begin
                            r_sel   <= w_gntIdx;
                            r_grant <= toOnehot(w_gntIdx);
                            r_busy  <= 1'b1;
                            r_count <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_count <= '0;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.sel   = r_sel;
    assign bus.grant = r_grant;
    assign bus.busy  = r_busy;
    assign bus.done  = w_fullBurst;

    demux1to8 u_demux (
        .d   (bus.in & r_busy),
        .sel (r_sel),
        .y   (bus.out)
    );

endmodule
